// File: rtl/aes_spi_pkg.sv
// Shared constants and state encoding for the AES SPI slave front-end.
package aes_spi_pkg;

   localparam int unsigned CNT_W = 9;

   localparam logic [1:0] KEY128 = 2'b00;
   localparam logic [1:0] KEY192 = 2'b01;
   localparam logic [1:0] KEY256 = 2'b10;

   localparam logic [CNT_W-1:0] LEN_KEY128 = 9'd130;
   localparam logic [CNT_W-1:0] LEN_KEY192 = 9'd194;
   localparam logic [CNT_W-1:0] LEN_KEY256 = 9'd258;
   localparam logic [CNT_W-1:0] LEN_MSG    = 9'd128;

   typedef enum logic [1:0] {
      S_KEY  = 2'd0,
      S_MSG  = 2'd1,
      S_WAIT = 2'd2,
      S_SEND = 2'd3
   } state_t;

   // Required key-frame length (code + key bits); code 11 has no valid length.
   function automatic logic [CNT_W-1:0] key_frame_len(input logic [1:0] code);
      case (code)
         KEY128:  return LEN_KEY128;
         KEY192:  return LEN_KEY192;
         KEY256:  return LEN_KEY256;
         default: return '0;
      endcase
   endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-flop synchroniser with rise/fall detection for an asynchronous SPI line.
module spi_edge_sync #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic d,
   output logic rise_c,
   output logic fall_c
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   // Free-running so a line already low at reset release yields no false edge.
   always_ff @(posedge clk) begin
      sync_q <= {sync_q[STAGES-2:0], d};
      prev_q <= sync_q[STAGES-1];
   end

   assign rise_c =  sync_q[STAGES-1] & ~prev_q;
   assign fall_c = ~sync_q[STAGES-1] &  prev_q;

endmodule

// File: rtl/aes_spi_slave_frontend.sv
// Oversampling SPI slave that deframes key/message frames for an AES core
// and serialises the core result back on sdo.
module aes_spi_slave_frontend
   import aes_spi_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned BLK_W       = 128,
   parameter int unsigned KEY_W       = 256
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cs_n,
   input  logic             sclk,
   input  logic             sdi,
   output logic             sdo,
   output logic [KEY_W-1:0] key_o,
   output logic [1:0]       key_len_o,
   output logic             key_load,
   output logic [BLK_W-1:0] blk_o,
   output logic             blk_start,
   input  logic [BLK_W-1:0] res_i,
   input  logic             res_valid,
   output logic             frame_err,
   output logic             rd_underrun
);

   localparam int unsigned      KIDX_W  = $clog2(KEY_W);
   localparam logic [CNT_W-1:0] MSG_LEN = CNT_W'(BLK_W);
   localparam logic [CNT_W-1:0] KEY_CAP = CNT_W'(KEY_W);

   logic sclk_rise, sclk_fall, cs_rise, cs_fall;
   logic [SYNC_STAGES-1:0] sdi_q;
   logic sdi_s;

   state_t state, state_nx;
   logic armed, res_ok;
   logic [CNT_W-1:0] bit_cnt;
   logic [1:0] code_sr;
   logic [KEY_W-1:0] key_sr;
   logic [BLK_W-1:0] blk_sr, res_q, tx_sr;

   logic key_load_nx, blk_start_nx, frame_err_nx, rd_underrun_nx;
   logic res_latch, res_clear;
   logic frame_end_c;
   logic [CNT_W-1:0] key_idx_c;

   spi_edge_sync #(.STAGES(SYNC_STAGES)) u_sclk_sync (
      .clk    (clk),
      .d      (sclk),
      .rise_c (sclk_rise),
      .fall_c (sclk_fall)
   );

   spi_edge_sync #(.STAGES(SYNC_STAGES)) u_cs_sync (
      .clk    (clk),
      .d      (cs_n),
      .rise_c (cs_rise),
      .fall_c (cs_fall)
   );

   // Same depth as sclk so sdi is aligned with the detected sclk edge.
   always_ff @(posedge clk) begin
      sdi_q <= {sdi_q[SYNC_STAGES-2:0], sdi};
   end
   assign sdi_s = sdi_q[SYNC_STAGES-1];

   assign frame_end_c = cs_rise & armed;
   assign key_idx_c   = bit_cnt - CNT_W'(2);

   always_ff @(posedge clk) begin
      if (rst) state <= S_KEY;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx       = state;
      key_load_nx    = 1'b0;
      blk_start_nx   = 1'b0;
      frame_err_nx   = 1'b0;
      rd_underrun_nx = 1'b0;
      res_latch      = 1'b0;
      res_clear      = 1'b0;
      case (state)
         S_KEY: begin
            if (frame_end_c) begin
               if (code_sr != 2'b11 && bit_cnt == key_frame_len(code_sr)) begin
                  key_load_nx = 1'b1;
                  state_nx    = S_MSG;
               end else begin
                  frame_err_nx = 1'b1;
               end
            end
         end
         S_MSG: begin
            if (frame_end_c) begin
               if (bit_cnt == MSG_LEN) begin
                  blk_start_nx = 1'b1;
                  state_nx     = S_WAIT;
               end else begin
                  frame_err_nx = 1'b1;
               end
            end
         end
         S_WAIT: begin
            res_latch = res_valid;
            // A result arriving mid-frame is held until that frame closes.
            if (frame_end_c) begin
               rd_underrun_nx = ~res_valid;
               if (res_valid || res_ok) state_nx = S_SEND;
            end else if (!armed && !cs_fall && (res_valid || res_ok)) begin
               state_nx = S_SEND;
            end
         end
         S_SEND: begin
            if (frame_end_c) begin
               if (bit_cnt == MSG_LEN) begin
                  res_clear = 1'b1;
                  state_nx  = S_KEY;
               end else begin
                  frame_err_nx = 1'b1;
               end
            end
         end
         default: state_nx = S_KEY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sdo         <= 1'b0;
         key_o       <= '0;
         key_len_o   <= KEY128;
         key_load    <= 1'b0;
         blk_o       <= '0;
         blk_start   <= 1'b0;
         frame_err   <= 1'b0;
         rd_underrun <= 1'b0;
         armed       <= 1'b0;
         res_ok      <= 1'b0;
         bit_cnt     <= '0;
         code_sr     <= '0;
         key_sr      <= '0;
         blk_sr      <= '0;
         res_q       <= '0;
         tx_sr       <= '0;
      end else begin
         key_load    <= key_load_nx;
         blk_start   <= blk_start_nx;
         frame_err   <= frame_err_nx;
         rd_underrun <= rd_underrun_nx;

         if (key_load_nx) begin
            key_o     <= key_sr;
            key_len_o <= code_sr;
         end
         if (blk_start_nx) blk_o <= blk_sr;

         if (res_latch)      res_q <= res_i;
         else if (res_clear) res_q <= '0;

         if (res_latch)             res_ok <= 1'b1;
         else if (state != S_WAIT)  res_ok <= 1'b0;

         // Receive side: bits beyond the key field are counted, never stored.
         if (cs_fall) begin
            armed   <= 1'b1;
            bit_cnt <= '0;
            code_sr <= '0;
            key_sr  <= '0;
         end else if (cs_rise) begin
            armed <= 1'b0;
         end else if (armed && sclk_rise) begin
            if (bit_cnt != '1) bit_cnt <= bit_cnt + CNT_W'(1);
            if (state == S_KEY) begin
               if (bit_cnt < CNT_W'(2))      code_sr <= {code_sr[0], sdi_s};
               else if (key_idx_c < KEY_CAP) key_sr[KIDX_W'(key_idx_c)] <= sdi_s;
            end else if (state == S_MSG) begin
               blk_sr <= {blk_sr[BLK_W-2:0], sdi_s};
            end
         end

         // Transmit side: every read frame restarts from the first result bit.
         if (state == S_SEND && cs_fall) begin
            tx_sr <= res_q;
            sdo   <= res_q[BLK_W-1];
         end else if (state == S_SEND && armed) begin
            if (sclk_fall) begin
               tx_sr <= {tx_sr[BLK_W-2:0], 1'b0};
               sdo   <= tx_sr[BLK_W-2];
            end
         end else begin
            sdo <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_aes_spi_slave_frontend.sv
// Directed bench for aes_spi_slave_frontend: key/message deframing, readback,
// malformed frames, read underrun and mid-frame reset.
module tb_aes_spi_slave_frontend;

   localparam int unsigned BLK_W = 128;
   localparam int unsigned KEY_W = 256;
   localparam int          HALF  = 6;

   localparam logic [127:0] K128 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [191:0] K192 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
   localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT2  = 128'hdeadbeef0badf00dcafebabe12345678;
   localparam logic [127:0] CT3  = 128'h0123456789abcdef0f1e2d3c4b5a6978;

   logic             clk = 1'b0;
   logic             rst, cs_n, sclk, sdi, sdo;
   logic [KEY_W-1:0] key_o;
   logic [1:0]       key_len_o;
   logic             key_load, blk_start, frame_err, rd_underrun, res_valid;
   logic [BLK_W-1:0] blk_o, res_i, rx;

   int n_chk = 0, n_err = 0;
   int n_kl = 0, n_bs = 0, n_fe = 0, n_ru = 0;
   int b_kl, b_bs, b_fe, b_ru;

   always #5 clk = ~clk;

   aes_spi_slave_frontend dut (
      .clk         (clk),
      .rst         (rst),
      .cs_n        (cs_n),
      .sclk        (sclk),
      .sdi         (sdi),
      .sdo         (sdo),
      .key_o       (key_o),
      .key_len_o   (key_len_o),
      .key_load    (key_load),
      .blk_o       (blk_o),
      .blk_start   (blk_start),
      .res_i       (res_i),
      .res_valid   (res_valid),
      .frame_err   (frame_err),
      .rd_underrun (rd_underrun)
   );

   // Strobe pulse counters, sampled away from the active edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (key_load)    n_kl++;
         if (blk_start)   n_bs++;
         if (frame_err)   n_fe++;
         if (rd_underrun) n_ru++;
      end
   end

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [255:0] exp_key(input logic [255:0] k, input int len);
      logic [255:0] r;
      r = '0;
      for (int i = 0; i < len; i++) r[i] = k[len-1-i];
      return r;
   endfunction

   // One SPI mode-0 frame; optional reset pulse at bit rst_at, optional
   // res_valid aligned with the detected cs_n rise.
   task automatic send_frame(input logic [511:0] data, input int len, input int rst_at,
                             input bit res_end, input logic [BLK_W-1:0] res_v,
                             output logic [BLK_W-1:0] rxd);
      rxd  = '0;
      cs_n = 1'b0;
      tick(HALF + 2);
      for (int i = 0; i < len; i++) begin
         if (i == rst_at) begin
            rst = 1'b1;
            tick(1);
            rst = 1'b0;
            check("rst_key_o", key_o, 256'(0));
            check("rst_key_len", 256'(key_len_o), 256'(0));
            check("rst_blk_o", 256'(blk_o), 256'(0));
            check("rst_strobes", 256'({key_load, blk_start, frame_err, rd_underrun, sdo}), 256'(0));
         end
         sdi = data[len-1-i];
         tick(HALF);
         if (i < BLK_W) rxd = {rxd[BLK_W-2:0], sdo};
         sclk = 1'b1;
         tick(HALF);
         sclk = 1'b0;
      end
      tick(HALF);
      cs_n = 1'b1;
      if (res_end) begin
         tick(2);
         res_i     = res_v;
         res_valid = 1'b1;
         tick(1);
         res_valid = 1'b0;
         tick(HALF);
      end else begin
         tick(HALF + 3);
      end
   endtask

   task automatic core_reply(input logic [BLK_W-1:0] r, input int dly);
      tick(dly);
      res_i     = r;
      res_valid = 1'b1;
      tick(1);
      res_valid = 1'b0;
   endtask

   task automatic send_key(input string tag, input logic [511:0] data, input int len,
                           input logic [1:0] code, input logic [255:0] kexp);
      logic [BLK_W-1:0] dummy;
      int kl0, fe0;
      kl0 = n_kl;
      fe0 = n_fe;
      send_frame(data, len, -1, 1'b0, '0, dummy);
      check({tag, "_key_load"}, 256'(n_kl - kl0), 256'(1));
      check({tag, "_frame_err"}, 256'(n_fe - fe0), 256'(0));
      check({tag, "_key_len"}, 256'(key_len_o), 256'(code));
      check({tag, "_key_o"}, key_o, kexp);
   endtask

   task automatic full_block(input string tag, input logic [BLK_W-1:0] pt, input logic [BLK_W-1:0] ct);
      logic [BLK_W-1:0] r;
      int bs0, fe0, ru0;
      bs0 = n_bs;
      fe0 = n_fe;
      ru0 = n_ru;
      send_frame(512'(pt), BLK_W, -1, 1'b0, '0, r);
      check({tag, "_blk_start"}, 256'(n_bs - bs0), 256'(1));
      check({tag, "_blk_o"}, 256'(blk_o), 256'(pt));
      core_reply(ct, 60);
      send_frame(512'(0), BLK_W, -1, 1'b0, '0, r);
      check({tag, "_rd_data"}, 256'(r), 256'(ct));
      check({tag, "_errs"}, 256'({n_fe - fe0, n_ru - ru0}), 256'(0));
   endtask

   initial begin
      rst = 1'b1; cs_n = 1'b1; sclk = 1'b0; sdi = 1'b0;
      res_valid = 1'b0; res_i = '0;
      tick(6);
      check("reset_key_o", key_o, 256'(0));
      check("reset_blk_o", 256'(blk_o), 256'(0));
      check("reset_outs", 256'({sdo, key_len_o, key_load, blk_start, frame_err, rd_underrun}), 256'(0));
      rst = 1'b0;
      tick(4);

      // 1: AES-128 key, message, readback
      send_key("t1", 512'({2'b00, K128}), 130, 2'b00, exp_key(256'(K128), 128));
      full_block("t1", PT, CT);

      // 2: 256- and 192-bit keys (key_load also proves return to S_KEY)
      send_key("t2_256", 512'({2'b10, K256}), 258, 2'b10, exp_key(K256, 256));
      full_block("t2a", PT, CT2);
      send_key("t2_192", 512'({2'b01, K192}), 194, 2'b01, exp_key(256'(K192), 192));
      full_block("t2b", PT, CT3);

      // 3: malformed key frames
      b_kl = n_kl; b_fe = n_fe;
      send_frame(512'({2'b11, K128}), 130, -1, 1'b0, '0, rx);
      check("t3_code11_err", 256'(n_fe - b_fe), 256'(1));
      check("t3_code11_key_o", key_o, exp_key(256'(K192), 192));
      send_frame(512'({2'b00, K128[127:1]}), 129, -1, 1'b0, '0, rx);
      check("t3_short_err", 256'(n_fe - b_fe), 256'(2));
      check("t3_no_key_load", 256'(n_kl - b_kl), 256'(0));
      send_key("t3_ok", 512'({2'b00, K128}), 130, 2'b00, exp_key(256'(K128), 128));

      // 4: read before the core finishes
      b_bs = n_bs; b_ru = n_ru; b_fe = n_fe;
      send_frame(512'(PT), BLK_W, -1, 1'b0, '0, rx);
      check("t4_blk_start", 256'(n_bs - b_bs), 256'(1));
      fork
         core_reply(CT, 60);
         begin
            tick(10);
            send_frame(512'(0), BLK_W, -1, 1'b0, '0, rx);
         end
      join
      check("t4_zero_data", 256'(rx), 256'(0));
      check("t4_underrun", 256'(n_ru - b_ru), 256'(1));
      send_frame(512'(0), BLK_W, -1, 1'b0, '0, rx);
      check("t4_retry_data", 256'(rx), 256'(CT));
      check("t4_underrun_once", 256'(n_ru - b_ru), 256'(1));
      check("t4_no_frame_err", 256'(n_fe - b_fe), 256'(0));

      // 5: reset in the middle of a message frame
      send_key("t5_pre", 512'({2'b10, K256}), 258, 2'b10, exp_key(K256, 256));
      send_frame(512'(PT), BLK_W, 50, 1'b0, '0, rx);
      b_bs = n_bs; b_fe = n_fe;
      tick(2);
      check("t5_after_key_o", key_o, 256'(0));
      check("t5_after_blk_o", 256'(blk_o), 256'(0));
      send_key("t5_post", 512'({2'b00, K128}), 130, 2'b00, exp_key(256'(K128), 128));
      check("t5_no_blk_start", 256'(n_bs - b_bs), 256'(0));
      check("t5_no_frame_err", 256'(n_fe - b_fe), 256'(0));
      full_block("t5", PT, CT);

      // 6: result arrives on the same cycle as the underrun frame end
      send_key("t6", 512'({2'b00, K128}), 130, 2'b00, exp_key(256'(K128), 128));
      b_ru = n_ru; b_fe = n_fe; b_bs = n_bs;
      send_frame(512'(PT), BLK_W, -1, 1'b0, '0, rx);
      check("t6_blk_start", 256'(n_bs - b_bs), 256'(1));
      send_frame(512'(0), BLK_W, -1, 1'b1, CT3, rx);
      check("t6_zero_data", 256'(rx), 256'(0));
      check("t6_no_underrun", 256'(n_ru - b_ru), 256'(0));
      send_frame(512'(0), BLK_W, -1, 1'b0, '0, rx);
      check("t6_rd_data", 256'(rx), 256'(CT3));
      check("t6_no_errs", 256'({n_fe - b_fe, n_ru - b_ru}), 256'(0));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
